// File: rtl/winograd_pkg.sv
// Shared widths and arithmetic helpers for the Winograd F(2,3) stream.
// Widths, data/inverse transforms and a signed saturation helper.
package winograd_pkg;

    typedef logic signed [63:0] wide_t;
    typedef logic [3:0][63:0]   quad_t;
    typedef logic [1:0][63:0]   pair_t;

    function automatic int v_size(input int d);
        return d + 1;
    endfunction

    function automatic int p_size(input int d, input int w);
        return v_size(d) + w;
    endfunction

    function automatic int y_size(input int d, input int w);
        return p_size(d, w) + 2;
    endfunction

    // B^T * d
    function automatic quad_t data_tf(input quad_t d);
        quad_t v;
        v[0] = $signed(d[0]) - $signed(d[2]);
        v[1] = $signed(d[1]) + $signed(d[2]);
        v[2] = $signed(d[2]) - $signed(d[1]);
        v[3] = $signed(d[1]) - $signed(d[3]);
        return v;
    endfunction

    // A^T * m
    function automatic pair_t inv_tf(input quad_t m);
        pair_t y;
        y[0] = $signed(m[0]) + $signed(m[1]) + $signed(m[2]);
        y[1] = $signed(m[1]) - $signed(m[2]) - $signed(m[3]);
        return y;
    endfunction

    function automatic wide_t sat(input wide_t x, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/winograd_lane.sv
// One lane of the F(2,3) pipeline: S0 transform, S1 multiply, S2 inverse + acc.
// Ports: clk_i/rst_ni, clear_i, load_i (S0), adv_i (S1), upd_i/last_i (S2),
// data_i d0..d3, weight_i u0..u3, sum_o y0/y1 after acc, sat_o overflow seen.
// WINOGRAD_ACC_SAT_EN: saturate the sum and track a sticky per-tile flag.
module winograd_lane
    import winograd_pkg::*;
#(
    parameter int D_SIZE   = 8,
    parameter int W_SIZE   = 8,
    parameter int ACC_SIZE = 27
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  logic                     adv_i,
    input  logic                     upd_i,
    input  logic                     last_i,
    input  logic [3:0][D_SIZE-1:0]   data_i,
    input  logic [3:0][W_SIZE-1:0]   weight_i,
    output logic [1:0][ACC_SIZE-1:0] sum_o,
    output logic                     sat_o
);

    localparam int V_SIZE = v_size(D_SIZE);
    localparam int P_SIZE = p_size(D_SIZE, W_SIZE);

    logic [3:0][V_SIZE-1:0]   v_q;
    logic [3:0][W_SIZE-1:0]   u_q;
    logic [3:0][P_SIZE-1:0]   m_q;
    logic [1:0][ACC_SIZE-1:0] acc_q;

    quad_t d_w;
    quad_t v_w;
    quad_t p_w;
    quad_t m_w;
    pair_t y_w;
    pair_t s_w;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            d_w[i] = wide_t'($signed(data_i[i]));
            p_w[i] = wide_t'($signed(v_q[i])) * wide_t'($signed(u_q[i]));
            m_w[i] = wide_t'($signed(m_q[i]));
        end
        v_w = data_tf(d_w);
        y_w = inv_tf(m_w);
        for (int j = 0; j < 2; j++) begin
            s_w[j] = $signed(y_w[j]) + wide_t'($signed(acc_q[j]));
        end
    end

`ifdef WINOGRAD_ACC_SAT_EN
    pair_t r_w;
    logic  ovf;
    logic  sticky_q;

    always_comb begin
        ovf = 1'b0;
        for (int j = 0; j < 2; j++) begin
            r_w[j]   = sat($signed(s_w[j]), ACC_SIZE);
            ovf      = ovf | (r_w[j] != s_w[j]);
            sum_o[j] = ACC_SIZE'(r_w[j]);
        end
    end

    // Flag covers every update of the current tile, including this one.
    assign sat_o = sticky_q | ovf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_q <= 1'b0;
        end else if (clear_i) begin
            sticky_q <= 1'b0;
        end else if (upd_i) begin
            sticky_q <= last_i ? 1'b0 : (sticky_q | ovf);
        end
    end
`else
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            sum_o[j] = ACC_SIZE'(s_w[j]);
        end
    end

    assign sat_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q   <= '0;
            u_q   <= '0;
            m_q   <= '0;
            acc_q <= '0;
        end else begin
            if (load_i) begin
                for (int i = 0; i < 4; i++) begin
                    v_q[i] <= V_SIZE'(v_w[i]);
                end
                u_q <= weight_i;
            end
            if (adv_i) begin
                for (int i = 0; i < 4; i++) begin
                    m_q[i] <= P_SIZE'(p_w[i]);
                end
            end
            if (clear_i) begin
                acc_q <= '0;
            end else if (upd_i) begin
                acc_q <= last_i ? '0 : sum_o;
            end
        end
    end

endmodule

// File: rtl/winograd_acc_stream.sv
// Streaming Winograd F(2,3) engine, LANES tiles per beat, channel accumulation.
// Ports: clk_i, rst_ni, clear_i; in_valid_i/in_ready_o/in_last_i/in_data_i/in_weight_i;
// out_valid_o/out_ready_i/out_data_o/out_sat_o. Option macro: WINOGRAD_ACC_SAT_EN.
module winograd_acc_stream
    import winograd_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int D_SIZE   = 8,
    parameter int W_SIZE   = 8,
    parameter int ACC_SIZE = D_SIZE + W_SIZE + 11
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic                                in_last_i,
    input  logic [LANES-1:0][3:0][D_SIZE-1:0]   in_data_i,
    input  logic [3:0][W_SIZE-1:0]              in_weight_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [LANES-1:0][1:0][ACC_SIZE-1:0] out_data_o,
    output logic                                out_sat_o
);

    if (ACC_SIZE < y_size(D_SIZE, W_SIZE)) begin : g_acc_chk
        $error("ACC_SIZE must be at least Y_SIZE");
    end

    logic stall;
    logic accept;
    logic upd;
    logic s0_vld_q;
    logic s0_last_q;
    logic s1_vld_q;
    logic s1_last_q;

    logic [LANES-1:0][1:0][ACC_SIZE-1:0] lane_sum;
    logic [LANES-1:0]                    lane_sat;

    // A held result freezes the whole pipe, accumulators included.
    assign stall      = out_valid_o & ~out_ready_i;
    assign in_ready_o = ~stall & ~clear_i;
    assign accept     = in_valid_i & in_ready_o;
    assign upd        = s1_vld_q & ~stall & ~clear_i;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        winograd_lane #(
            .D_SIZE  (D_SIZE),
            .W_SIZE  (W_SIZE),
            .ACC_SIZE(ACC_SIZE)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .load_i  (accept),
            .adv_i   (~stall),
            .upd_i   (upd),
            .last_i  (s1_last_q),
            .data_i  (in_data_i[l]),
            .weight_i(in_weight_i),
            .sum_o   (lane_sum[l]),
            .sat_o   (lane_sat[l])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_vld_q    <= 1'b0;
            s0_last_q   <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_sat_o   <= 1'b0;
        end else if (clear_i) begin
            s0_vld_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (!stall) begin
            s0_vld_q  <= accept;
            s0_last_q <= in_last_i;
            s1_vld_q  <= s0_vld_q;
            s1_last_q <= s0_last_q;
            // Not stalled: either no result is held or it is taken now,
            // so a new tile may replace it without a bubble.
            if (s1_vld_q && s1_last_q) begin
                out_valid_o <= 1'b1;
                out_data_o  <= lane_sum;
                out_sat_o   <= |lane_sat;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_winograd_acc_stream.sv
// Scoreboard bench for winograd_acc_stream with ACC_SIZE = Y_SIZE.
// Expected tiles are queued by the driver and popped by an output monitor.
module tb_winograd_acc_stream;

    localparam int LANES = 4;
    localparam int D     = 8;
    localparam int W     = 8;
    localparam int ACC   = 19;

    typedef logic [LANES-1:0][1:0][ACC-1:0] res_t;
    typedef struct packed {
        res_t data;
        logic sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic in_last = 1'b0;
    logic [LANES-1:0][3:0][D-1:0] in_data = '0;
    logic [3:0][W-1:0] in_weight = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    res_t out_data;
    logic out_sat;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    logic [3:0][7:0] d1, d2, dov, u1, u2, uov;

    always #5 clk = ~clk;

    winograd_acc_stream #(
        .LANES(LANES), .D_SIZE(D), .W_SIZE(W), .ACC_SIZE(ACC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_last_i  (in_last),
        .in_data_i  (in_data),
        .in_weight_i(in_weight),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_sat_o  (out_sat)
    );

    task automatic chk_bit(input string name, input logic got, input logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic chk_res(input string name, input res_t got, input res_t req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Lane l gets y*(l+1) when scaled (inputs scaled by l+1).
    function automatic res_t mk(input int y0, input int y1, input bit scale);
        res_t r;
        for (int l = 0; l < LANES; l++) begin
            int k;
            k = scale ? l + 1 : 1;
            r[l][0] = ACC'(y0 * k);
            r[l][1] = ACC'(y1 * k);
        end
        return r;
    endfunction

    task automatic push(input res_t r, input logic s);
        exp_t e;
        e.data = r;
        e.sat  = s;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [3:0][7:0] d, input bit scale);
        for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < 4; i++) begin
                int t;
                t = $signed(d[i]) * (scale ? l + 1 : 1);
                in_data[l][i] = t[7:0];
            end
        end
    endtask

    task automatic send(input logic [3:0][7:0] d, input logic [3:0][7:0] u,
                        input bit last, input bit scale);
        int n;
        logic rdy;
        n = 0;
        set_beat(d, scale);
        in_weight = u;
        in_last   = last;
        in_valid  = 1'b1;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no in_ready, required in_ready=1");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk_bit("wait_valid", out_valid, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk_bit("drain_empty", exp_q.size() == 0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %h, required no output", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk_res("out_data", out_data, e.data);
                chk_bit("out_sat", out_sat, e.sat);
            end
        end
    end

    initial begin
        d1  = {8'd4, 8'd3, 8'd2, 8'd1};
        d2  = {8'd8, 8'd6, 8'd4, 8'd2};
        u1  = {4{8'd1}};
        u2  = {4{8'd2}};
        dov = {8'h80, 8'h80, 8'h7f, 8'h7f};
        uov = {8'h7f, 8'h80, 8'h80, 8'h7f};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_out_sat", out_sat, 1'b0);
        chk_res("rst_out_data", out_data, '0);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // 1: single-beat tile, latency c+3
        push(mk(8, 12, 1), 1'b0);
        send(d1, u2, 1, 1);
        @(negedge clk);
        chk_bit("lat_c1", out_valid, 1'b0);
        @(negedge clk);
        chk_bit("lat_c2", out_valid, 1'b0);
        @(negedge clk);
        chk_bit("lat_c3", out_valid, 1'b1);
        @(posedge clk);
        #1;
        idle(2);

        // 2: three channels accumulated into one tile
        push(mk(24, 36, 1), 1'b0);
        send(d1, u2, 0, 1);
        send(d1, u2, 0, 1);
        send(d1, u2, 1, 1);
        drain();

        // 3: back-pressure holds output, then releases all tiles in order
        out_ready = 1'b0;
        push(mk(8, 12, 1), 1'b0);
        push(mk(16, 24, 1), 1'b0);
        push(mk(4, 6, 1), 1'b0);
        send(d1, u2, 1, 1);
        send(d2, u2, 1, 1);
        send(d1, u1, 1, 1);
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_bit("stall_in_ready", in_ready, 1'b0);
            chk_res("stall_hold", out_data, mk(8, 12, 1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // 4: clear discards partial acc and a simultaneous beat
        send(d1, u2, 0, 1);
        send(d1, u2, 0, 1);
        idle(3);
        set_beat(d1, 1);
        in_weight = u2;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        clear     = 1'b1;
        @(negedge clk);
        chk_bit("clear_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        push(mk(8, 12, 1), 1'b0);
        send(d1, u2, 1, 1);
        drain();

        // 4b: clear drops a pending output
        out_ready = 1'b0;
        send(d1, u2, 1, 1);
        wait_valid();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk_bit("clear_drop", out_valid, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(2);

        // 5: accumulator overflow over five channels
`ifdef WINOGRAD_ACC_SAT_EN
        push(mk(262143, -262144, 0), 1'b1);
`else
        push(mk(-198523, 199803, 0), 1'b0);
`endif
        for (int b = 0; b < 5; b++) begin
            send(dov, uov, b == 4, 0);
        end
        drain();

        // 6: async reset mid-tile
        send(d1, u2, 0, 1);
        send(d1, u2, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_res("midrst_out_data", out_data, '0);
        chk_bit("midrst_out_sat", out_sat, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        push(mk(8, 12, 1), 1'b0);
        send(d1, u2, 1, 1);
        drain();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
